// File: rtl/serial_add_arbiter.sv
// Two-requester adder sharing a single 4-bit ripple-carry slice.
// Each accepted operation is summed one slice per clock, LSB slice first.
module serial_add_arbiter #(
    parameter int NSLICE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic [4*NSLICE-1:0] req0_a,
    input  logic [4*NSLICE-1:0] req0_b,
    input  logic                req0_cin,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [4*NSLICE-1:0] req1_a,
    input  logic [4*NSLICE-1:0] req1_b,
    input  logic                req1_cin,
    output logic                req1_ready,
    output logic                res_valid,
    output logic [4*NSLICE-1:0] res_sum,
    output logic                res_cout,
    output logic                res_id,
    input  logic                res_ready
);

    localparam int W  = 4 * NSLICE;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_acc;
    logic [W-1:0]    next_acc;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic            op_id;
    logic            last;
    logic            grant;
    logic [3:0]      slice_a;
    logic [3:0]      slice_b;
    logic [3:0]      slice_s;
    logic [4:0]      c;

    // On a tie the requester that was not granted last wins; otherwise any lone requester.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last;
        else                          grant = req1_valid;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid &&  grant;

    always_comb begin
        slice_a  = a_reg[int'(cnt)*4 +: 4];
        slice_b  = b_reg[int'(cnt)*4 +: 4];
        slice_s  = '0;
        c        = '0;
        c[0]     = carry;
        for (int i = 0; i < 4; i++) begin
            slice_s[i] = slice_a[i] ^ slice_b[i] ^ c[i];
            c[i+1]     = (slice_a[i] & slice_b[i]) | (c[i] & (slice_a[i] ^ slice_b[i]));
        end
        next_acc = sum_acc;
        next_acc[int'(cnt)*4 +: 4] = slice_s;
    end

    // Results are published only on entry to DONE, so outputs stay frozen while a new sum builds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_acc   <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            op_id     <= 1'b0;
            last      <= 1'b1;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        a_reg <= grant ? req1_a : req0_a;
                        b_reg <= grant ? req1_b : req0_b;
                        carry <= grant ? req1_cin : req0_cin;
                        op_id <= grant;
                        last  <= grant;
                        cnt   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum_acc <= next_acc;
                    carry   <= c[4];
                    if (cnt == LAST_SLICE) begin
                        res_sum   <= next_acc;
                        res_cout  <= c[4];
                        res_id    <= op_id;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter with hand-computed expected sums.
module tb_serial_add_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_cin, req0_ready;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_cin, req1_ready;
    logic [15:0] req1_a, req1_b;
    logic        res_valid, res_cout, res_id, res_ready;
    logic [15:0] res_sum;

    int vectors     = 0;
    int miscompares = 0;

    serial_add_arbiter #(.NSLICE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .res_ready  (res_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and park on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic waitResult(input string tag, output int cycles);
        cycles = 0;
        while (res_valid !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        checkOutput({tag, "_latency"}, cycles, 4);
    endtask

    // Issue one operation from a single requester, wait for it and hand it off.
    task automatic applyStimulus(input string tag, input logic id, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin,
                                 input logic [15:0] exp_sum, input logic exp_cout);
        int cycles;
        req0_valid = (id == 1'b0);
        req1_valid = (id == 1'b1);
        req0_a = a; req0_b = b; req0_cin = cin;
        req1_a = a; req1_b = b; req1_cin = cin;
        #1;
        checkOutput({tag, "_ready"}, {req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'hDEAD; req1_a = 16'hBEEF;
        waitResult(tag, cycles);
        checkOutput({tag, "_sum"},  res_sum,  exp_sum);
        checkOutput({tag, "_cout"}, res_cout, exp_cout);
        checkOutput({tag, "_id"},   res_id,   id);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checkOutput({tag, "_handoff"}, res_valid, 0);
    endtask

    initial begin
        int cycles;
        rst_n = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
        res_ready = 0;
        #12;
        checkOutput("reset_valid", res_valid, 0);
        checkOutput("reset_sum",   res_sum,   0);
        checkOutput("reset_cout",  res_cout,  0);
        checkOutput("reset_id",    res_id,    0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] single-requester operations");
        applyStimulus("r0_1p1",  1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
        applyStimulus("r1_wrap", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        applyStimulus("r1_cin",  1'b1, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1);

        $display("[TB] tie from reset, alternating grants");
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        res_ready = 1'b1;
        req0_valid = 1; req0_a = 16'h0003; req0_b = 16'h0005; req0_cin = 0;
        req1_valid = 1; req1_a = 16'h000F; req1_b = 16'h0001; req1_cin = 0;
        #1;
        checkOutput("tie_first_ready", {req1_ready, req0_ready}, 1);
        tick();
        checkOutput("tie_add_readys", {req1_ready, req0_ready}, 0);
        waitResult("tie_op0", cycles);
        checkOutput("tie_op0_sum", res_sum, 16'h0008);
        checkOutput("tie_op0_id",  res_id,  0);
        tick();
        checkOutput("tie_op0_handoff", res_valid, 0);
        checkOutput("tie_second_ready", {req1_ready, req0_ready}, 2);
        tick();
        waitResult("tie_op1", cycles);
        checkOutput("tie_op1_sum",  res_sum,  16'h0010);
        checkOutput("tie_op1_cout", res_cout, 0);
        checkOutput("tie_op1_id",   res_id,   1);
        req0_valid = 0; req1_valid = 0;
        tick();
        res_ready = 1'b0;

        $display("[TB] consumer stall in DONE");
        req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h1111; req0_cin = 0;
        req1_valid = 1; req1_a = 16'h0F0F; req1_b = 16'h0101; req1_cin = 0;
        #1;
        checkOutput("stall_ready", {req1_ready, req0_ready}, 1);
        tick();
        waitResult("stall", cycles);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_valid",  res_valid, 1);
            checkOutput("stall_sum",    res_sum,   16'h2345);
            checkOutput("stall_id",     res_id,    0);
            checkOutput("stall_readys", {req1_ready, req0_ready}, 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checkOutput("stall_handoff", res_valid, 0);
        checkOutput("stall_next_grant", {req1_ready, req0_ready}, 2);
        req0_valid = 0; req1_valid = 0;

        $display("[TB] reset during ADD");
        req0_valid = 1; req0_a = 16'h0102; req0_b = 16'h0304; req0_cin = 0;
        tick();
        req0_valid = 0;
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", res_valid, 0);
        checkOutput("abort_sum",   res_sum,   0);
        checkOutput("abort_id",    res_id,    0);
        tick();
        rst_n = 1'b1;
        cycles = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (res_valid === 1'b1) cycles++;
        end
        checkOutput("abort_no_result", cycles, 0);
        applyStimulus("post_abort", 1'b1, 16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0);

        $display("[TB] dropped request before grant");
        req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h1111; req0_cin = 0;
        req1_valid = 1; req1_a = 16'h00FF; req1_b = 16'h0F01; req1_cin = 0;
        #1;
        checkOutput("drop_pre_ready", {req1_ready, req0_ready}, 1);
        req0_valid = 0;
        #1;
        checkOutput("drop_post_ready", {req1_ready, req0_ready}, 2);
        tick();
        req1_valid = 0;
        waitResult("drop", cycles);
        checkOutput("drop_sum", res_sum, 16'h1000);
        checkOutput("drop_id",  res_id,  1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        req0_valid = 1; req1_valid = 1;
        #1;
        checkOutput("drop_tie_after", {req1_ready, req0_ready}, 1);
        req0_valid = 0; req1_valid = 0;
        tick();

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add_arbiter.md
SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

Interface
REQ-001 SHALL have parameter NSLICE, default 4: number of 4-bit slices; operand width W = 4*NSLICE (default 16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has an operation pending.
REQ-005 SHALL have port req0_a, req0_b  input  W each  requester 0 operands.
REQ-006 SHALL have port req0_cin  input  1  requester 0 carry-in.
REQ-007 SHALL have port req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 SHALL have ports req1_valid, req1_a, req1_b, req1_cin, req1_ready, identical to REQ-004..007, for requester 1.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_sum  output  W  result sum, modulo 2^W.
REQ-011 SHALL have port res_cout  output  1  carry out of the MSB slice.
REQ-012 SHALL have port res_id  output  1  index of the requester that owns the result.
REQ-013 SHALL have port res_ready  input  1  consumer accepts the result.

Function
REQ-014 SHALL share one internal 4-bit ripple-carry slice (four 1-bit full adders) between both requesters; no other adder hardware.
REQ-015 SHALL implement FSM states IDLE, ADD and DONE.
REQ-016 IDLE: SHALL set reqN_ready = reqN_valid AND grant==N, combinational; at most one ready high per cycle.
REQ-017 Grant: one valid requester wins; both valid -> the requester not granted last; pointer updates only on acceptance.
REQ-018 Acceptance (valid AND ready at an edge): SHALL capture a, b, cin and the id into registers, clear the slice counter, and go to ADD.
REQ-019 Requesters may change or drop inputs after acceptance; before acceptance, SHALL re-arbitrate every cycle with no grant lock.
REQ-020 ADD: on each edge SHALL add slice k (bits 4k+3..4k) with the carry register (captured cin for k=0) and store the 4 sum bits and the carry-out.
REQ-021 SHALL leave ADD after slice NSLICE-1 and enter DONE, so res_valid rises exactly NSLICE cycles after the acceptance edge.
REQ-022 DONE: SHALL hold res_valid=1 and keep res_sum, res_cout and res_id stable until res_valid AND res_ready, then go to IDLE.
REQ-023 SHALL keep both reqN_ready low in ADD and DONE; no acceptance in the same cycle as result handoff; peak throughput one op per NSLICE+2 cycles.
REQ-024 SHALL set res_valid=0 in IDLE and ADD; res_sum, res_cout and res_id hold their last values outside DONE.
REQ-025 Overflow SHALL wrap: res_sum = (a+b+cin) mod 2^W, res_cout = bit W of the full sum.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, slice counter 0, carry register 0, and the grant pointer to "last=1" (requester 0 wins the first tie).
REQ-027 Reset asserted mid-ADD or mid-DONE SHALL discard the in-flight operation with no result produced; operation resumes from IDLE on the first edge after rst_n rises.

Verification
REQ-028 req0: a=0x0001, b=0x0001, cin=0 -> accepted; res_valid after 4 cycles, res_sum=0x0002, res_cout=0, res_id=0.
REQ-029 req1: a=0xFFFF, b=0x0001, cin=0 -> res_sum=0x0000, res_cout=1, res_id=1; a=0xAAAA, b=0x5555, cin=1 -> res_sum=0x0000, res_cout=1.
REQ-030 Both valid from reset, res_ready=1: req0 (0x0003+0x0005) served first with res_sum=0x0008, then req1 (0x000F+0x0001) with res_sum=0x0010; the ready pulses alternate.
REQ-031 res_ready=0 for 5 cycles in DONE -> res_valid and outputs held stable, both readys low, and no new acceptance until the handoff.
REQ-032 rst_n pulsed low during the second ADD cycle -> all outputs 0 immediately, no res_valid for the aborted op; the next request completes normally.
REQ-033 req0_valid dropped before grant while req1 is valid -> req1 is accepted; the pointer is unchanged by the dropped request.
